// File: rtl/hamming_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hamming_pkg : shared Hamming(15,11) constants, bit map and parity function |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package hamming_pkg;

  localparam int HAM_N = 15;
  localparam int HAM_K = 11;
  localparam int HAM_P = 4;

  localparam int PAR_POS  [HAM_P] = '{1, 2, 4, 8};
  localparam int DATA_POS [HAM_K] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  // Data bits scattered into their codeword slots, parity slots left at zero.
  function automatic logic [HAM_N-1:0] ham_place(input logic [HAM_K-1:0] data);
    logic [HAM_N-1:0] code;
    code = '0;
    for (int i = 0; i < HAM_K; i++) begin
      code[DATA_POS[i]-1] = data[i];
    end
    return code;
  endfunction

  // XOR of the positions of all set data bits gives {p8,p4,p2,p1}; the decoder
  // syndrome uses the same identity over the full codeword.
  function automatic logic [HAM_P-1:0] ham_parity(input logic [HAM_K-1:0] data);
    logic [HAM_N-1:0] code;
    logic [HAM_P-1:0] par;
    code = ham_place(data);
    par  = '0;
    for (int pos = 1; pos <= HAM_N; pos++) begin
      if (code[pos-1]) begin
        par = par ^ 4'(pos);
      end
    end
    return par;
  endfunction

  function automatic logic [HAM_N-1:0] ham_assemble(input logic [HAM_K-1:0] data,
                                                    input logic [HAM_P-1:0] par);
    logic [HAM_N-1:0] code;
    code = ham_place(data);
    for (int k = 0; k < HAM_P; k++) begin
      code[PAR_POS[k]-1] = par[k];
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ham_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ham_pipe_stage : generic valid/ready register slice of WIDTH bits          |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module ham_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // An empty upstream loads a bubble; the payload is only refreshed by real words.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hamming_enc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hamming_enc_pipe : 2-stage Hamming(15,11) encoder with error injection     |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module hamming_enc_pipe
  import hamming_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter bit INJECT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      in_data,
  input  logic [3:0]       err_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      out_code,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int S1_W = HAM_K + 4 + HAM_P;

  logic [3:0]       err_sel;
  logic [S1_W-1:0]  s1_in, s1_out;
  logic             s1_valid, s2_ready;
  logic [HAM_K-1:0] s1_dat;
  logic [3:0]       s1_err;
  logic [HAM_P-1:0] s1_par;
  logic [HAM_N-1:0] flip_mask, code_asm;
  logic [CNT_W-1:0] word_cnt_d, word_cnt_q;

  generate
    if (INJECT_EN) begin : g_inject
      assign err_sel = err_pos;
    end else begin : g_no_inject
      assign err_sel = err_pos & 4'd0;
    end
  endgenerate

  assign s1_in = {in_data, err_sel, ham_parity(in_data)};

  ham_pipe_stage #(.WIDTH(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  assign {s1_dat, s1_err, s1_par} = s1_out;

  // err_pos==0 shifts the one-hot out of range, leaving an all-zero mask.
  always_comb begin
    flip_mask = HAM_N'((16'd1 << s1_err) >> 1);
    code_asm  = ham_assemble(s1_dat, s1_par) ^ flip_mask;
  end

  ham_pipe_stage #(.WIDTH(HAM_N)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (code_asm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_code)
  );

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (out_valid && out_ready) begin
      word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_enc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hamming_enc_pipe : randomized bench with behavioural Hamming model      |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_hamming_enc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [10:0] in_data;
  logic [3:0]  err_pos;
  logic        in_ready, out_valid, in_ready4, out_valid4;
  logic [14:0] out_code, out_code4;
  logic [15:0] word_cnt;
  logic [3:0]  word_cnt4;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [10:0] d;
    logic [3:0]  e;
  } word_t;
  word_t q[$];

  hamming_enc_pipe #(.CNT_W(16), .INJECT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .err_pos(err_pos), .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .word_cnt(word_cnt)
  );

  hamming_enc_pipe #(.CNT_W(4), .INJECT_EN(1'b0)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .err_pos(err_pos), .out_valid(out_valid4), .out_ready(out_ready), .out_code(out_code4),
    .word_cnt(word_cnt4)
  );

  // Codeword built position by position: powers of two are parity, the rest
  // take data bits in ascending order; each parity makes its group's ones even.
  function automatic logic [14:0] ref_code(input logic [10:0] d, input logic [3:0] e);
    logic [14:0] c;
    int j, ones;
    c = '0;
    j = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    end
    for (int k = 1; k < 16; k = k * 2) begin
      ones = 0;
      for (int p = 1; p <= 15; p++) begin
        if ((p & k) != 0 && c[p-1]) ones++;
      end
      c[k-1] = (ones % 2) == 1;
    end
    if (e != 4'd0) c[int'(e)-1] = ~c[int'(e)-1];
    return c;
  endfunction

  function automatic logic [10:0] ref_decode(input logic [14:0] c);
    logic [14:0] x;
    logic [10:0] d;
    int s, j;
    x = c;
    s = 0;
    j = 0;
    d = '0;
    for (int p = 1; p <= 15; p++) begin
      if (c[p-1]) s = s ^ p;
    end
    if (s != 0) x[s-1] = ~x[s-1];
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = x[p-1];
        j++;
      end
    end
    return d;
  endfunction

  // Samples handshakes mid-cycle with the inputs already driven, logs accepted
  // words, then advances to just past the next rising edge.
  task automatic tick(output bit inf, output bit outf, output logic [14:0] c, output logic [14:0] c4);
    #1;
    inf  = !rst && in_valid && in_ready;
    outf = !rst && out_valid && out_ready;
    c    = out_code;
    c4   = out_code4;
    if (inf) q.push_back('{d: in_data, e: err_pos});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 11'h5A5; err_pos = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_code !== 15'h0) begin bad++; $display("FAIL reset_out_code got=%h exp=0000", out_code); end
    total++; if (word_cnt !== 16'h0) begin bad++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    q.delete();
  endtask

  task automatic test_single();
    bit inf, outf;
    logic [14:0] c, c4;
    int at;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 11'h000; err_pos = 4'd0;
    tick(inf, outf, c, c4);
    in_valid = 1'b0;
    at = -1;
    for (int k = 1; k <= 6; k++) begin
      tick(inf, outf, c, c4);
      if (outf && at < 0) begin
        at = k;
        total++; if (c !== 15'h0000) begin bad++; $display("FAIL single_code got=%h exp=0000", c); end
        void'(q.pop_front());
      end
    end
    total++; if (at != 2) begin bad++; $display("FAIL single_latency got=%0d exp=2", at); end
    total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL single_word_cnt got=%0d exp=1", word_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] din [3];
    logic [14:0] exp [3];
    bit inf, outf;
    logic [14:0] c, c4;
    int nout;
    din = '{11'h7FF, 11'h001, 11'h400};
    exp = '{15'h7FFF, 15'h0007, 15'h408B};
    do_reset();
    out_ready = 1'b1; err_pos = 4'd0;
    nout = 0;
    for (int t = 0; t < 8; t++) begin
      in_valid = (t < 3);
      in_data  = (t < 3) ? din[t] : 11'h0;
      tick(inf, outf, c, c4);
      if (outf) begin
        void'(q.pop_front());
        total++;
        if (nout > 2 || t != nout + 2 || c !== exp[nout % 3]) begin
          bad++; $display("FAIL b2b_out idx=%0d cycle=%0d got=%h exp=%h", nout, t, c, exp[nout % 3]);
        end
        nout++;
      end
    end
    total++; if (nout != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", nout); end
  endtask

  task automatic test_stall();
    logic [10:0] w [4];
    bit inf, outf;
    logic [14:0] c, c4;
    int idx, nout;
    word_t x;
    do_reset();
    for (int i = 0; i < 4; i++) w[i] = 11'($urandom);
    idx = 0; nout = 0;
    out_ready = 1'b0; err_pos = 4'd0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = 1'b1; in_data = w[idx];
      tick(inf, outf, c, c4);
      if (inf) idx++;
    end
    total++; if (idx != 2) begin bad++; $display("FAIL stall_accepts got=%0d exp=2", idx); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    total++;
    if (out_valid !== 1'b1 || out_code !== ref_code(w[0], 4'd0)) begin
      bad++; $display("FAIL stall_hold got=%b/%h exp=1/%h", out_valid, out_code, ref_code(w[0], 4'd0));
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && nout < 4; cyc++) begin
      in_valid = (idx < 4);
      in_data  = (idx < 4) ? w[idx] : 11'h0;
      tick(inf, outf, c, c4);
      if (inf) idx++;
      if (outf) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL stall_spurious got=%h exp=none", c);
        end else begin
          x = q.pop_front();
          if (c !== ref_code(w[nout], 4'd0) || x.d !== w[nout]) begin
            bad++; $display("FAIL stall_order idx=%0d got=%h exp=%h", nout, c, ref_code(w[nout], 4'd0));
          end
        end
        nout++;
      end
    end
    in_valid = 1'b0;
    total++; if (nout != 4) begin bad++; $display("FAIL stall_drain got=%0d exp=4", nout); end
  endtask

  task automatic test_inject();
    logic [3:0]  ev   [2];
    logic [14:0] exp  [2];
    bit inf, outf;
    logic [14:0] c, c4;
    int nout;
    ev  = '{4'd8, 4'd15};
    exp = '{15'h0080, 15'h4000};
    do_reset();
    out_ready = 1'b1; in_data = 11'h000;
    nout = 0;
    for (int t = 0; t < 8; t++) begin
      in_valid = (t < 2);
      err_pos  = (t < 2) ? ev[t] : 4'd0;
      tick(inf, outf, c, c4);
      if (outf) begin
        void'(q.pop_front());
        total++;
        if (nout > 1 || c !== exp[nout % 2]) begin
          bad++; $display("FAIL inject_code idx=%0d got=%h exp=%h", nout, c, exp[nout % 2]);
        end
        total++;
        if (c4 !== 15'h0000) begin bad++; $display("FAIL inject_disabled idx=%0d got=%h exp=0000", nout, c4); end
        nout++;
      end
    end
    total++; if (nout != 2) begin bad++; $display("FAIL inject_count got=%0d exp=2", nout); end
  endtask

  task automatic test_roundtrip();
    bit inf, outf;
    logic [14:0] c, c4;
    int idx, nout, errs;
    word_t x;
    do_reset();
    idx = 0; nout = 0; errs = 0;
    for (int cyc = 0; cyc < 20000 && nout < 2048; cyc++) begin
      in_valid  = (idx < 2048) && ($urandom_range(0, 3) != 0);
      in_data   = 11'(idx);
      err_pos   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      tick(inf, outf, c, c4);
      if (inf) idx++;
      if (outf) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rt_spurious got=%h exp=none", c);
        end else begin
          x = q.pop_front();
          if (c !== ref_code(x.d, x.e)) begin
            bad++; $display("FAIL rt_code got=%h exp=%h", c, ref_code(x.d, x.e));
          end
          total++;
          if (ref_decode(c) !== x.d) begin
            bad++; $display("FAIL rt_decode got=%h exp=%h", ref_decode(c), x.d);
          end
          total++;
          if (c4 !== ref_code(x.d, 4'd0)) begin
            bad++; $display("FAIL rt_clean got=%h exp=%h", c4, ref_code(x.d, 4'd0));
          end
          if (x.d !== 11'(nout)) errs++;
        end
        nout++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (nout != 2048 || errs != 0) begin bad++; $display("FAIL rt_count got=%0d/%0d exp=2048/0", nout, errs); end
  endtask

  task automatic test_reset_midstream();
    bit inf, outf;
    logic [14:0] c, c4;
    int stale;
    do_reset();
    out_ready = 1'b0; err_pos = 4'd0;
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b1; in_data = 11'($urandom);
      tick(inf, outf, c, c4);
    end
    out_ready = 1'b1; rst = 1'b1;
    tick(inf, outf, c, c4);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL midrst_word_cnt got=%0d exp=0", word_cnt); end
    q.delete();
    stale = 0;
    for (int t = 0; t < 5; t++) begin
      tick(inf, outf, c, c4);
      if (outf) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL midrst_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_wrap();
    bit inf, outf;
    logic [14:0] c, c4;
    int n;
    logic [3:0] exp4;
    do_reset();
    out_ready = 1'b1; err_pos = 4'd0;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 17; cyc++) begin
      in_valid = (q.size() + n < 17);
      in_data  = 11'($urandom);
      tick(inf, outf, c, c4);
      if (outf) begin
        void'(q.pop_front());
        n++;
        if (n >= 15) begin
          exp4 = (n == 15) ? 4'd15 : (n == 16) ? 4'd0 : 4'd1;
          total++;
          if (word_cnt4 !== exp4) begin bad++; $display("FAIL wrap_cnt4 n=%0d got=%0d exp=%0d", n, word_cnt4, exp4); end
        end
      end
    end
    in_valid = 1'b0;
    total++; if (word_cnt !== 16'd17) begin bad++; $display("FAIL wrap_cnt16 got=%0d exp=17", word_cnt); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; err_pos = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_inject();
    test_roundtrip();
    test_reset_midstream();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
